// File: rtl/muldiv_seq_if.sv
// muldiv_seq_if: request/response bundle between a requester (master) and the muldiv unit (slave).
interface muldiv_seq_if #(parameter int XLEN = 32);
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      op;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    modport master (output in_valid, op, rs1_val, rs2_val, out_ready, input in_ready, out_valid, result);
    modport slave  (input in_valid, op, rs1_val, rs2_val, out_ready, output in_ready, out_valid, result);
endinterface

// File: rtl/muldiv_seq.sv
// muldiv_seq: sequential RISC-V M-extension unit (shift-add multiply, restoring divide on magnitudes).
// Define MULDIV_FAST_MUL_EN to complete all multiplies in one cycle with a full-width multiplier.
module muldiv_seq #(parameter int XLEN = 32) (
    input logic         clk,
    input logic         rst,
    muldiv_seq_if.slave bus
);
    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0] op_q, op_d;
    logic neg_q, neg_d;
    logic [XLEN-1:0] m_q, m_d, res_q, res_d;
    logic [2*XLEN-1:0] acc_q, acc_d, step;
    logic [2*XLEN:0] shl;
    logic [XLEN:0] trial, mul_sum;
    logic s1, s2, sa, sb, div_zero, div_ovf;
    logic [XLEN-1:0] a_mag, b_mag;

    // Apply the final sign to the unsigned magnitude result and pick the requested half.
    function automatic logic [XLEN-1:0] fin(input logic [2:0] o, input logic n, input logic [2*XLEN-1:0] w);
        logic [2*XLEN-1:0] p;
        logic [XLEN-1:0] h;
        p = n ? -w : w;
        h = o[1] ? w[2*XLEN-1:XLEN] : w[XLEN-1:0];
        return o[2] ? (n ? -h : h) : (o == 3'd0 ? p[XLEN-1:0] : p[2*XLEN-1:XLEN]);
    endfunction

    always_comb begin
        s1 = bus.op inside {3'd1, 3'd2, 3'd4, 3'd6};
        s2 = bus.op inside {3'd1, 3'd4, 3'd6};
        sa = s1 && bus.rs1_val[XLEN-1];
        sb = s2 && bus.rs2_val[XLEN-1];
        a_mag = sa ? -bus.rs1_val : bus.rs1_val;
        b_mag = sb ? -bus.rs2_val : bus.rs2_val;
        div_zero = bus.op[2] && bus.rs2_val == '0;
        div_ovf = bus.op[2] && !bus.op[0] && bus.rs1_val == {1'b1, {(XLEN-1){1'b0}}} && bus.rs2_val == '1;
        // acc holds {remainder, quotient} when dividing and {product high, multiplier} when multiplying
        shl = {acc_q, 1'b0};
        trial = shl[2*XLEN:XLEN] - {1'b0, m_q};
        mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, m_q} : '0);
        step = op_q[2] ? (trial[XLEN] ? shl[2*XLEN-1:0] : {trial[XLEN-1:0], shl[XLEN-1:1], 1'b1})
                       : {mul_sum, acc_q[XLEN-1:1]};
        state_d = state_q;
        cnt_d = cnt_q;
        op_d = op_q;
        neg_d = neg_q;
        m_d = m_q;
        acc_d = acc_q;
        res_d = res_q;
        if (state_q == IDLE && bus.in_valid) begin
            op_d = bus.op;
            neg_d = (bus.op[2] && bus.op[1]) ? sa : sa ^ sb;
            m_d = bus.op[2] ? b_mag : a_mag;
            acc_d = {{XLEN{1'b0}}, bus.op[2] ? a_mag : b_mag};
            cnt_d = '0;
            state_d = CALC;
            if (div_zero) begin
                res_d = bus.op[1] ? bus.rs1_val : '1;
                state_d = DONE;
            end else if (div_ovf) begin
                res_d = bus.op[1] ? '0 : bus.rs1_val;
                state_d = DONE;
            end
`ifdef MULDIV_FAST_MUL_EN
            else if (!bus.op[2]) begin
                res_d = fin(bus.op, neg_d, {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag});
                state_d = DONE;
            end
`else
`endif
        end else if (state_q == CALC) begin
            acc_d = step;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
                res_d = fin(op_q, neg_q, step);
                state_d = DONE;
            end
        end else if (state_q == DONE && bus.out_ready) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q <= '0;
            op_q <= '0;
            neg_q <= 1'b0;
            m_q <= '0;
            acc_q <= '0;
            res_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            op_q <= op_d;
            neg_q <= neg_d;
            m_q <= m_d;
            acc_q <= acc_d;
            res_q <= res_d;
        end
    end

    assign bus.in_ready = state_q == IDLE;
    assign bus.out_valid = state_q == DONE;
    assign bus.result = res_q;
endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 SHALL have parameter: XLEN, 32, operand/result width (even, >= 8).
REQ-002 SHALL have port: clk  in  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port: in_valid  in  1  request valid.
REQ-005 SHALL have port: in_ready  out  1  unit accepts a request this cycle.
REQ-006 SHALL have port: op  in  3  0 mul, 1 mulh, 2 mulhsu, 3 mulhu, 4 div, 5 divu, 6 rem, 7 remu.
REQ-007 SHALL have port: rs1_val  in  XLEN  dividend / multiplicand.
REQ-008 SHALL have port: rs2_val  in  XLEN  divisor / multiplier.
REQ-009 SHALL have port: out_valid  out  1  result valid.
REQ-010 SHALL have port: out_ready  in  1  consumer takes result.
REQ-011 SHALL have port: result  out  XLEN  operation result.

Function
REQ-012 SHALL implement FSM states IDLE, CALC, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-013 SHALL accept a request on an edge where in_valid && in_ready, capturing op, rs1_val and rs2_val; later input changes SHALL NOT affect the result.
REQ-014 SHALL, for div/divu/rem/remu with nonzero divisor and no overflow, go IDLE->CALC, run a restoring radix-2 divider on magnitudes for exactly XLEN CALC cycles, then CALC->DONE, so out_valid rises XLEN+1 edges after accept.
REQ-015 SHALL make signed quotient negative iff operand signs differ, and signed remainder take the sign of the dividend.
REQ-016 SHALL, on divide by zero, return all-ones for div/divu and rs1_val for rem/remu, going IDLE->DONE directly (latency 1).
REQ-017 SHALL, on signed overflow (rs1 = -2^(XLEN-1), rs2 = -1), return rs1 for div and 0 for rem, latency 1.
REQ-018 SHALL compute mul as the low XLEN bits of the product; mulh/mulhsu/mulhu as the high XLEN bits of the 2*XLEN product with signed*signed, signed*unsigned and unsigned*unsigned operands respectively.
REQ-019 SHALL hold result and out_valid stable in DONE until out_ready is high; DONE->IDLE on that edge.
REQ-020 SHALL NOT accept a new request on the same edge a result is consumed (in_ready low in DONE).
REQ-021 SHALL treat all 8 op encodings as valid; no error output.

Reset
REQ-022 SHALL, when rst is high at an edge, enter IDLE, clear result to 0, out_valid to 0, in_ready to 1 next cycle, and clear the iteration counter.
REQ-023 SHALL abandon any in-flight operation on reset with no result delivered; rst SHALL take priority over in_valid and out_ready.

Configuration
REQ-024 SHALL, with macro MULDIV_FAST_MUL_EN defined, compute all multiply ops with a single-cycle 2*XLEN-bit multiplier going IDLE->DONE (latency 1).
REQ-025 SHALL, without MULDIV_FAST_MUL_EN, compute multiplies by shift-add over XLEN CALC cycles (latency XLEN+1, as REQ-014); results SHALL be bit-identical in both builds.

Verification (XLEN=32)
REQ-026 SHALL cover: div 7 by 0xFFFFFFFE (-2) -> 0xFFFFFFFD at edge 33 after accept; rem same operands -> 0x00000001.
REQ-027 SHALL cover: divu 0x12345678 by 0 -> 0xFFFFFFFF; remu 5 by 0 -> 0x00000005; both out_valid 1 edge after accept.
REQ-028 SHALL cover: div 0x80000000 by 0xFFFFFFFF -> 0x80000000; rem -> 0x00000000; latency 1.
REQ-029 SHALL cover: mulhu 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; mulh same -> 0x00000000; mulhsu 0xFFFFFFFF*2 -> 0xFFFFFFFF; mul 0x00010000*0x00010000 -> 0; run with and without MULDIV_FAST_MUL_EN.
REQ-030 SHALL cover: out_ready held low 5 cycles in DONE -> result stable, in_ready 0; out_ready high -> IDLE, in_ready 1 next cycle.
REQ-031 SHALL cover: rst pulsed at CALC cycle 10 of a div -> next cycle in_ready 1, out_valid 0, result 0; then a new divu 100/7 -> 0x0000000E.
